// File: rtl/ddr4_cmd_decoder.sv
`default_nettype none
// ============================================================================
// ddr4_cmd_decoder : DDR4 pin decoder producing registered command pulses,
//                    CKE power-mode tracking and illegal-encoding counting.
// Revision 1.0
// ============================================================================
module ddr4_cmd_decoder #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int ERRW    = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    cke,
  input  logic                                    cs_n,
  input  logic                                    act_n,
  input  logic                                    ras_n,
  input  logic                                    cas_n,
  input  logic                                    we_n,
  input  logic                                    a10,
  input  logic [((BGWIDTH == 0) ? 1 : BGWIDTH)-1:0] bg,
  input  logic [BAWIDTH-1:0]                      ba,
  output logic                                    ACT,
  output logic                                    PR,
  output logic                                    PRA,
  output logic                                    RD,
  output logic                                    RDA,
  output logic                                    WR,
  output logic                                    WRA,
  output logic                                    REF,
  output logic                                    MRW,
  output logic                                    SRF,
  output logic                                    SRX,
  output logic                                    PD,
  output logic                                    PDX,
  output logic                                    CKEH,
  output logic                                    CKEL,
  output logic [((BGWIDTH == 0) ? 1 : BGWIDTH)-1:0] bg_o,
  output logic [BAWIDTH-1:0]                      ba_o,
  output logic [1:0]                              mode,
  output logic                                    illegal,
  output logic [ERRW-1:0]                         err_cnt
);

  localparam int BGW = (BGWIDTH == 0) ? 1 : BGWIDTH;

  localparam int P_ACT  = 0;
  localparam int P_PR   = 1;
  localparam int P_PRA  = 2;
  localparam int P_RD   = 3;
  localparam int P_RDA  = 4;
  localparam int P_WR   = 5;
  localparam int P_WRA  = 6;
  localparam int P_REF  = 7;
  localparam int P_MRW  = 8;
  localparam int P_SRF  = 9;
  localparam int P_SRX  = 10;
  localparam int P_PD   = 11;
  localparam int P_PDX  = 12;
  localparam int P_CKEH = 13;
  localparam int P_CKEL = 14;
  localparam int NP     = 15;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_PDOWN  = 2'd1,
    MODE_SREF   = 2'd2
  } mode_e;

  mode_e             mode_q, mode_d;
  logic              cke_q, cke_d;
  logic [NP-1:0]     pulse_q, pulse_d;
  logic              illegal_q, illegal_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
  logic [BGW-1:0]    bg_q, bg_d;
  logic [BAWIDTH-1:0] ba_q, ba_d;

  logic [2:0] rcw;
  logic       is_idle;
  logic       is_ref;

  assign rcw     = {ras_n, cas_n, we_n};
  assign is_idle = cs_n || (act_n && (rcw == 3'b111));
  assign is_ref  = !cs_n && act_n && (rcw == 3'b001);

  // Bank-group pins carry no meaning without bank groups.
  if (BGWIDTH > 0) begin : g_bg
    assign bg_d = bg;
  end else begin : g_no_bg
    assign bg_d = '0;
  end

  assign ba_d = ba;

  always_comb begin
    pulse_d   = '0;
    illegal_d = 1'b0;
    mode_d    = mode_q;
    cke_d     = cke;

    pulse_d[P_CKEH] = !cke_q && cke;
    pulse_d[P_CKEL] = cke_q && !cke;

    if (cke_q && cke) begin
      if ((mode_q == MODE_NORMAL) && !cs_n) begin
        if (!act_n) begin
          pulse_d[P_ACT] = 1'b1;
        end else begin
          case (rcw)
            3'b000:  pulse_d[P_MRW] = 1'b1;
            3'b001:  pulse_d[P_REF] = 1'b1;
            3'b010:  pulse_d[a10 ? P_PRA : P_PR] = 1'b1;
            3'b100:  pulse_d[a10 ? P_WRA : P_WR] = 1'b1;
            3'b101:  pulse_d[a10 ? P_RDA : P_RD] = 1'b1;
            3'b011:  illegal_d = 1'b1;
            default: ;
          endcase
        end
      end
    end else if (cke_q && !cke) begin
      if (mode_q == MODE_NORMAL) begin
        if (is_ref) begin
          pulse_d[P_SRF] = 1'b1;
          mode_d         = MODE_SREF;
        end else begin
          // Anything but DES/NOP on entry is dropped and flagged.
          pulse_d[P_PD]  = 1'b1;
          mode_d         = MODE_PDOWN;
          illegal_d      = !is_idle;
        end
      end
    end else if (!cke_q && cke) begin
      pulse_d[P_PDX] = (mode_q == MODE_PDOWN);
      pulse_d[P_SRX] = (mode_q == MODE_SREF);
      mode_d         = MODE_NORMAL;
      illegal_d      = !is_idle;
    end

    err_cnt_d = err_cnt_q;
    if (illegal_d && (err_cnt_q != {ERRW{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERRW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cke_q     <= 1'b1;
      mode_q    <= MODE_NORMAL;
      pulse_q   <= '0;
      illegal_q <= 1'b0;
      err_cnt_q <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
    end else begin
      cke_q     <= cke_d;
      mode_q    <= mode_d;
      pulse_q   <= pulse_d;
      illegal_q <= illegal_d;
      err_cnt_q <= err_cnt_d;
      bg_q      <= bg_d;
      ba_q      <= ba_d;
    end
  end

  assign ACT     = pulse_q[P_ACT];
  assign PR      = pulse_q[P_PR];
  assign PRA     = pulse_q[P_PRA];
  assign RD      = pulse_q[P_RD];
  assign RDA     = pulse_q[P_RDA];
  assign WR      = pulse_q[P_WR];
  assign WRA     = pulse_q[P_WRA];
  assign REF     = pulse_q[P_REF];
  assign MRW     = pulse_q[P_MRW];
  assign SRF     = pulse_q[P_SRF];
  assign SRX     = pulse_q[P_SRX];
  assign PD      = pulse_q[P_PD];
  assign PDX     = pulse_q[P_PDX];
  assign CKEH    = pulse_q[P_CKEH];
  assign CKEL    = pulse_q[P_CKEL];
  assign bg_o    = bg_q;
  assign ba_o    = ba_q;
  assign mode    = mode_q;
  assign illegal = illegal_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_decoder.sv
`default_nettype none
// ============================================================================
// tb_ddr4_cmd_decoder : scenario tasks plus randomized traffic against a
//                       command-name level reference model.
// Revision 1.0
// ============================================================================
module tb_ddr4_cmd_decoder;

  localparam int ERRW = 2;

  localparam int B_ACT = 14, B_PR = 13, B_PRA = 12, B_RD = 11, B_RDA = 10;
  localparam int B_WR = 9, B_WRA = 8, B_REF = 7, B_MRW = 6, B_SRF = 5;
  localparam int B_SRX = 4, B_PD = 3, B_PDX = 2, B_CKEH = 1, B_CKEL = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, a10;
  logic [1:0] bg, ba;
  logic ACT, PR, PRA, RD, RDA, WR, WRA, REF, MRW, SRF, SRX, PD, PDX, CKEH, CKEL;
  logic [1:0] bg_o, ba_o, mode;
  logic illegal;
  logic [ERRW-1:0] err_cnt;
  logic [14:0] dut_p;

  assign dut_p = {ACT, PR, PRA, RD, RDA, WR, WRA, REF, MRW, SRF, SRX, PD, PDX, CKEH, CKEL};

  ddr4_cmd_decoder #(.BGWIDTH(2), .BAWIDTH(2), .ERRW(ERRW)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .a10(a10), .bg(bg), .ba(ba),
    .ACT(ACT), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA),
    .REF(REF), .MRW(MRW), .SRF(SRF), .SRX(SRX), .PD(PD), .PDX(PDX),
    .CKEH(CKEH), .CKEL(CKEL), .bg_o(bg_o), .ba_o(ba_o), .mode(mode),
    .illegal(illegal), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state, expressed in command names and mode numbers.
  int         m_cke_q, m_mode, m_err;
  logic [14:0] exp_p;
  logic        exp_ill;
  logic [1:0]  exp_bg, exp_ba;

  function automatic string cmd_name(logic c, logic a, logic r, logic s, logic w, logic ap);
    if (c) return "DES";
    if (!a) return "ACT";
    case ({r, s, w})
      3'b000:  return "MRW";
      3'b001:  return "REF";
      3'b010:  return ap ? "PRA" : "PR";
      3'b011:  return "RSV";
      3'b100:  return ap ? "WRA" : "WR";
      3'b101:  return ap ? "RDA" : "RD";
      3'b110:  return "ZQ";
      default: return "NOP";
    endcase
  endfunction

  function automatic int bit_of(string n);
    case (n)
      "ACT": return B_ACT;   "PR":  return B_PR;   "PRA": return B_PRA;
      "RD":  return B_RD;    "RDA": return B_RDA;  "WR":  return B_WR;
      "WRA": return B_WRA;   "REF": return B_REF;  "MRW": return B_MRW;
      "SRF": return B_SRF;   "SRX": return B_SRX;  "PD":  return B_PD;
      "PDX": return B_PDX;   "CKEH": return B_CKEH;
      default: return B_CKEL;
    endcase
  endfunction

  task automatic model_reset();
    m_cke_q = 1; m_mode = 0; m_err = 0;
    exp_p = '0; exp_ill = 1'b0; exp_bg = '0; exp_ba = '0;
  endtask

  task automatic model_step();
    string n;
    bit idle;
    n = cmd_name(cs_n, act_n, ras_n, cas_n, we_n, a10);
    idle = (n == "DES") || (n == "NOP");
    exp_p = '0;
    exp_ill = 1'b0;
    if (m_cke_q == 1 && cke) begin
      if (m_mode == 0) begin
        if (n == "RSV") exp_ill = 1'b1;
        else if (!idle && n != "ZQ") exp_p[bit_of(n)] = 1'b1;
      end
    end else if (m_cke_q == 1 && !cke) begin
      exp_p[B_CKEL] = 1'b1;
      if (m_mode == 0) begin
        if (n == "REF") begin exp_p[B_SRF] = 1'b1; m_mode = 2; end
        else begin exp_p[B_PD] = 1'b1; m_mode = 1; exp_ill = !idle; end
      end
    end else if (m_cke_q == 0 && cke) begin
      exp_p[B_CKEH] = 1'b1;
      if (m_mode == 1) exp_p[B_PDX] = 1'b1;
      if (m_mode == 2) exp_p[B_SRX] = 1'b1;
      m_mode = 0;
      exp_ill = !idle;
    end
    if (exp_ill && m_err < 3) m_err++;
    m_cke_q = cke ? 1 : 0;
    exp_bg = bg;
    exp_ba = ba;
  endtask

  task automatic set_cmd(string n, logic ap);
    cs_n  = (n == "DES");
    act_n = (n != "ACT");
    a10   = ap;
    case (n)
      "MRW":        {ras_n, cas_n, we_n} = 3'b000;
      "REF":        {ras_n, cas_n, we_n} = 3'b001;
      "PR":         {ras_n, cas_n, we_n} = 3'b010;
      "RSV":        {ras_n, cas_n, we_n} = 3'b011;
      "WR":         {ras_n, cas_n, we_n} = 3'b100;
      "RD":         {ras_n, cas_n, we_n} = 3'b101;
      "ZQ":         {ras_n, cas_n, we_n} = 3'b110;
      default:      {ras_n, cas_n, we_n} = 3'(($urandom % 2) ? 3'b111 : 3'b010);
    endcase
    if (n == "NOP") {ras_n, cas_n, we_n} = 3'b111;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cke = 1'b1;
    set_cmd("DES", 1'b0);
    bg = '0; ba = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cke = 1'b1;
    set_cmd("DES", 1'b0);
    bg = 2'd3; ba = 2'd2;
    #1;
    checks++;
    if ({dut_p, illegal, err_cnt, mode, bg_o, ba_o} !== '0) begin
      failures++;
      $display("FAIL reset_state: got p=%h ill=%b err=%0d mode=%0d bg=%0d ba=%0d required all 0",
               dut_p, illegal, err_cnt, mode, bg_o, ba_o);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_act();
    do_reset();
    set_cmd("ACT", 1'b0);
    bg = 2'd1; ba = 2'd1;
    step();
    checks++;
    if (dut_p !== (15'd1 << B_ACT) || bg_o !== 2'd1 || ba_o !== 2'd1) begin
      failures++;
      $display("FAIL act_pulse: got p=%h bg=%0d ba=%0d required p=%h bg=1 ba=1",
               dut_p, bg_o, ba_o, 15'd1 << B_ACT);
    end
    set_cmd("DES", 1'b0);
    step();
    checks++;
    if (dut_p !== '0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL act_one_cycle: got p=%h ill=%b required p=0 ill=0", dut_p, illegal);
    end
  endtask

  task automatic test_back_to_back();
    string base[3] = '{"WR", "RD", "PR"};
    int    want[6] = '{B_WR, B_RD, B_PR, B_WRA, B_RDA, B_PRA};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_cmd(base[i % 3], (i >= 3));
      bg = 2'($urandom); ba = 2'($urandom);
      step();
      checks++;
      if (dut_p !== (15'd1 << want[i]) || illegal !== 1'b0 || bg_o !== exp_bg || ba_o !== exp_ba) begin
        failures++;
        $display("FAIL b2b_%0d: got p=%h ill=%b bg=%0d ba=%0d required p=%h ill=0 bg=%0d ba=%0d",
                 i, dut_p, illegal, bg_o, ba_o, 15'd1 << want[i], exp_bg, exp_ba);
      end
    end
  endtask

  task automatic test_self_refresh();
    do_reset();
    set_cmd("REF", 1'b0);
    cke = 1'b0;
    step();
    checks++;
    if (dut_p !== ((15'd1 << B_SRF) | (15'd1 << B_CKEL)) || mode !== 2'd2) begin
      failures++;
      $display("FAIL sref_entry: got p=%h mode=%0d required p=%h mode=2",
               dut_p, mode, (15'd1 << B_SRF) | (15'd1 << B_CKEL));
    end
    for (int i = 0; i < 10; i++) begin
      {cs_n, act_n, ras_n, cas_n, we_n, a10} = 6'($urandom);
      step();
      checks++;
      if (dut_p !== '0 || illegal !== 1'b0 || mode !== 2'd2) begin
        failures++;
        $display("FAIL sref_low_%0d: got p=%h ill=%b mode=%0d required p=0 ill=0 mode=2",
                 i, dut_p, illegal, mode);
      end
    end
    cke = 1'b1;
    set_cmd("DES", 1'b0);
    step();
    checks++;
    if (dut_p !== ((15'd1 << B_SRX) | (15'd1 << B_CKEH)) || mode !== 2'd0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL sref_exit: got p=%h mode=%0d ill=%b required p=%h mode=0 ill=0",
               dut_p, mode, illegal, (15'd1 << B_SRX) | (15'd1 << B_CKEH));
    end
  endtask

  task automatic test_pd_illegal_exit();
    do_reset();
    set_cmd("NOP", 1'b0);
    cke = 1'b0;
    step();
    checks++;
    if (dut_p !== ((15'd1 << B_PD) | (15'd1 << B_CKEL)) || mode !== 2'd1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL pd_entry: got p=%h mode=%0d ill=%b required p=%h mode=1 ill=0",
               dut_p, mode, illegal, (15'd1 << B_PD) | (15'd1 << B_CKEL));
    end
    set_cmd("DES", 1'b0);
    step();
    cke = 1'b1;
    set_cmd("ACT", 1'b0);
    step();
    checks++;
    if (dut_p !== ((15'd1 << B_PDX) | (15'd1 << B_CKEH)) || illegal !== 1'b1 ||
        err_cnt !== 2'd1 || mode !== 2'd0) begin
      failures++;
      $display("FAIL pd_exit_act: got p=%h ill=%b err=%0d mode=%0d required p=%h ill=1 err=1 mode=0",
               dut_p, illegal, err_cnt, mode, (15'd1 << B_PDX) | (15'd1 << B_CKEH));
    end
  endtask

  task automatic test_err_saturation();
    int want[4] = '{1, 2, 3, 3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cmd("RSV", 1'($urandom));
      step();
      checks++;
      if (illegal !== 1'b1 || err_cnt !== 2'(want[i]) || dut_p !== '0) begin
        failures++;
        $display("FAIL rsv_sat_%0d: got ill=%b err=%0d p=%h required ill=1 err=%0d p=0",
                 i, illegal, err_cnt, dut_p, want[i]);
      end
    end
  endtask

  task automatic test_reset_in_sref();
    do_reset();
    set_cmd("REF", 1'b0);
    cke = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dut_p, illegal, err_cnt, mode, bg_o, ba_o} !== '0) begin
      failures++;
      $display("FAIL async_reset_sref: got p=%h ill=%b err=%0d mode=%0d required all 0",
               dut_p, illegal, err_cnt, mode);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cke = 1'b1;
    set_cmd("DES", 1'b0);
    step();
    checks++;
    if (dut_p !== '0 || illegal !== 1'b0 || mode !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_des: got p=%h ill=%b mode=%0d required p=0 ill=0 mode=0",
               dut_p, illegal, mode);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      {cs_n, act_n, ras_n, cas_n, we_n, a10} = 6'($urandom);
      if ($urandom_range(0, 2) == 0) cs_n = 1'b1;
      bg = 2'($urandom); ba = 2'($urandom);
      if ($urandom_range(0, 5) == 0) cke = ~cke;
      step();
      checks++;
      if ({dut_p, illegal, err_cnt, mode, bg_o, ba_o} !==
          {exp_p, exp_ill, 2'(m_err), 2'(m_mode), exp_bg, exp_ba}) begin
        failures++;
        $display("FAIL random_%0d: got p=%h ill=%b err=%0d mode=%0d bg=%0d ba=%0d required p=%h ill=%b err=%0d mode=%0d bg=%0d ba=%0d",
                 i, dut_p, illegal, err_cnt, mode, bg_o, ba_o,
                 exp_p, exp_ill, m_err, m_mode, exp_bg, exp_ba);
      end
    end
  endtask

  initial begin
    test_reset();
    test_act();
    test_back_to_back();
    test_self_refresh();
    test_pd_illegal_exit();
    test_err_saturation();
    test_reset_in_sref();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
